ram_arbiter: RTL and testbench

- Two-requester arbiter and access sequencer for one single-port Hack-style RAM block (RAM8/RAM64 family: combinational read, write on clock edge when load=1).
- Each requester uses a req/ack handshake. The block grants the RAM round-robin, drives address/in/load for exactly one cycle, and returns registered read data with a one-cycle ack pulse.
- It sits between CPU-side memory clients and the chapter-03 RAM datapath.

---
 rtl/ram_arbiter_if.sv | 20 ++
 rtl/ram_arbiter.sv | 86 ++++++++
 tb/tb_ram_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester and RAM-side bus of ram_arbiter
// master: requesters + RAM (drive req/we/addr/wdata, ram_out; observe ack/rdata, RAM strobes, busy)
// slave: the arbiter. Macro ARB_LOCK_EN adds lock0/lock1.
interface ram_arbiter_if #(parameter int DATA_W = 16, parameter int ADDR_W = 3);
  logic req0, we0, ack0, req1, we1, ack1, ram_load, busy;
  logic [ADDR_W-1:0] addr0, addr1, ram_address;
  logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, ram_in, ram_out;
`ifdef ARB_LOCK_EN
  logic lock0, lock1;
  modport master (output req0, we0, addr0, wdata0, lock0, req1, we1, addr1, wdata1, lock1, ram_out,
                  input ack0, rdata0, ack1, rdata1, ram_load, ram_address, ram_in, busy);
  modport slave (input req0, we0, addr0, wdata0, lock0, req1, we1, addr1, wdata1, lock1, ram_out,
                 output ack0, rdata0, ack1, rdata1, ram_load, ram_address, ram_in, busy);
`else
  modport master (output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_out,
                  input ack0, rdata0, ack1, rdata1, ram_load, ram_address, ram_in, busy);
  modport slave (input req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_out,
                 output ack0, rdata0, ack1, rdata1, ram_load, ram_address, ram_in, busy);
`endif
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-requester access sequencer for a single-port Hack RAM
// Ports: clk, rst_n (sync, active low), bus (ram_arbiter_if.slave: req/we/addr/wdata/ack/rdata per
// requester, ram_load/ram_address/ram_in/ram_out toward the RAM, busy).
// Optional macro ARB_LOCK_EN: lock0/lock1 let a requester keep the RAM across accesses.
module ram_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic clk,
  input logic rst_n,
  ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;
  state_t state;
  logic prio, gnt, we_q, r0, r1, sel;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
`ifdef ARB_LOCK_EN
  logic lock_q, owner;
  // a held lock hides the non-owner's request
  always_comb begin
    r0 = bus.req0 & (!lock_q | !owner);
    r1 = bus.req1 & (!lock_q | owner);
  end
`else
  always_comb begin
    r0 = bus.req0;
    r1 = bus.req1;
  end
`endif
  assign sel = (r0 & r1) ? prio : r1;
  assign bus.ram_address = addr_q;
  assign bus.ram_in = wdata_q;
  // rst_n gate keeps an aborted SERVE from committing a write
  assign bus.ram_load = (state == SERVE) & we_q & rst_n;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
      prio <= 1'b0;
      gnt <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
`ifdef ARB_LOCK_EN
      lock_q <= 1'b0;
      owner <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (r0 | r1) begin
          gnt <= sel;
          we_q <= sel ? bus.we1 : bus.we0;
          addr_q <= sel ? bus.addr1 : bus.addr0;
          wdata_q <= sel ? bus.wdata1 : bus.wdata0;
          state <= SERVE;
        end
        SERVE: begin
          if (!we_q && !gnt) bus.rdata0 <= bus.ram_out;
          if (!we_q && gnt) bus.rdata1 <= bus.ram_out;
          bus.ack0 <= !gnt;
          bus.ack1 <= gnt;
`ifdef ARB_LOCK_EN
          lock_q <= gnt ? bus.lock1 : bus.lock0;
          owner <= gnt;
`endif
          state <= DONE;
        end
        default: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
`ifdef ARB_LOCK_EN
          if (!lock_q) prio <= !gnt;
`else
          prio <= !gnt;
`endif
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized scoreboard bench for ram_arbiter against a queue-level reference model
module tb_ram_arbiter;
  typedef struct packed {logic we; logic lock; logic [2:0] addr; logic [15:0] data;} cmd_t;
  typedef struct packed {logic port; logic we; logic [2:0] addr; logic [15:0] wdata; logic [15:0] rd;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] ram [8] = '{default: 16'h0};
  logic [15:0] ref_mem [8] = '{default: 16'h0};
  exp_t sb[$];
  bit m_prio, m_lock, m_owner;
  int vectors = 0, errors = 0;

  ram_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();
  ram_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;
  assign bus.ram_out = ram[bus.ram_address];
  always @(posedge clk) if (bus.ram_load) ram[bus.ram_address] <= bus.ram_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: serve queued commands one at a time; a contested grant goes to prio,
  // the loser waits; after a service prio points at the other port unless a lock holds
  task automatic plan(input cmd_t c0[$], input cmd_t c1[$]);
    bit h0, h1, k;
    cmd_t c;
    exp_t e;
    while (c0.size() + c1.size() > 0) begin
      h0 = c0.size() > 0;
      h1 = c1.size() > 0;
      if (m_lock) begin
        h0 = h0 && !m_owner;
        h1 = h1 && m_owner;
      end
      if (!h0 && !h1) break;
      if (h0 && h1) k = m_prio;
      else k = h1;
      c = k ? c1.pop_front() : c0.pop_front();
      e = '{port: k, we: c.we, addr: c.addr, wdata: c.data, rd: ref_mem[c.addr]};
      if (c.we) ref_mem[c.addr] = c.data;
      sb.push_back(e);
      m_lock = c.lock;
      m_owner = k;
      if (!m_lock) m_prio = !k;
    end
  endtask

  task automatic present(input cmd_t c0[$], input cmd_t c1[$]);
    bus.req0 = c0.size() > 0;
    bus.req1 = c1.size() > 0;
    if (c0.size() > 0) {bus.we0, bus.addr0, bus.wdata0} = {c0[0].we, c0[0].addr, c0[0].data};
    if (c1.size() > 0) {bus.we1, bus.addr1, bus.wdata1} = {c1[0].we, c1[0].addr, c1[0].data};
`ifdef ARB_LOCK_EN
    if (c0.size() > 0) bus.lock0 = c0[0].lock;
    if (c1.size() > 0) bus.lock1 = c1[0].lock;
`endif
  endtask

  // each requester keeps req high while it has commands, moving to the next one on its ack
  task automatic run(input cmd_t c0[$], input cmd_t c1[$]);
    int n = 0;
    plan(c0, c1);
    present(c0, c1);
    while (c0.size() + c1.size() > 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ack0 && c0.size() > 0) void'(c0.pop_front());
      if (bus.ack1 && c1.size() > 0) void'(c1.pop_front());
      present(c0, c1);
    end
    if (n >= 300) chk("run_timeout", 32'(n), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk(input logic we, input logic [2:0] addr, input logic [15:0] data, input logic lock);
    mk = '{we: we, lock: lock, addr: addr, data: data};
  endfunction

  initial begin : monitor
    logic r;
    logic [15:0] x0, x1;
    exp_t e;
    int cyc, last;
    x0 = 0;
    x1 = 0;
    cyc = 0;
    last = -10;
    forever begin
      @(posedge clk);
      r = rst_n;
      cyc++;
      @(negedge clk);
      if (!r) begin
        x0 = 0;
        x1 = 0;
      end
      if (bus.ram_load) begin
        if (sb.size() == 0) chk("load_unexpected", 32'(bus.ram_load), 0);
        else begin
          chk("load_we", 32'(bus.ram_load), 32'(sb[0].we));
          chk("load_addr", 32'(bus.ram_address), 32'(sb[0].addr));
          chk("load_data", 32'(bus.ram_in), 32'(sb[0].wdata));
        end
      end
      chk("ack_both", 32'(bus.ack0 & bus.ack1), 0);
      if (bus.ack0 | bus.ack1) begin
        if (sb.size() == 0) chk("ack_unexpected", 32'({bus.ack1, bus.ack0}), 0);
        else begin
          e = sb.pop_front();
          chk("ack_port", 32'({bus.ack1, bus.ack0}), e.port ? 2 : 1);
          chk("ack_spacing_ge3", 32'(cyc - last >= 3), 1);
          last = cyc;
          if (!e.we && e.port) x1 = e.rd;
          if (!e.we && !e.port) x0 = e.rd;
        end
      end
      chk("rdata0", 32'(bus.rdata0), 32'(x0));
      chk("rdata1", 32'(bus.rdata1), 32'(x1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t a[$], b[$];
    rst_n = 1'b0;
    {bus.req0, bus.we0, bus.addr0, bus.wdata0} = '0;
    {bus.req1, bus.we1, bus.addr1, bus.wdata1} = '0;
`ifdef ARB_LOCK_EN
    bus.lock0 = 1'b0;
    bus.lock1 = 1'b0;
`endif
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(bus.ack0), 0);
    chk("rst_ack1", 32'(bus.ack1), 0);
    chk("rst_load", 32'(bus.ram_load), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rdata0", 32'(bus.rdata0), 0);
    chk("rst_rdata1", 32'(bus.rdata1), 0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n = 1'b1;
    m_prio = 0;
    m_lock = 0;
    @(posedge clk);
    #1;
    // port 0 write with cycle-exact timing
    a = {mk(1'b1, 3'd3, 16'hBEEF, 1'b0)};
    b = {};
    plan(a, b);
    present(a, b);
    @(posedge clk);
    #1;
    chk("w_busy", 32'(bus.busy), 1);
    chk("w_load", 32'(bus.ram_load), 1);
    chk("w_addr", 32'(bus.ram_address), 3);
    chk("w_ack_early", 32'(bus.ack0), 0);
    @(posedge clk);
    #1;
    chk("w_ack", 32'(bus.ack0), 1);
    chk("w_load_once", 32'(bus.ram_load), 0);
    bus.req0 = 1'b0;
    @(posedge clk);
    #1;
    chk("w_ack_pulse", 32'(bus.ack0), 0);
    chk("w_idle", 32'(bus.busy), 0);
    run({mk(1'b0, 3'd3, 16'h0, 1'b0)}, b);
    // contention
    run({mk(1'b1, 3'd1, 16'h1111, 1'b0)}, {mk(1'b1, 3'd2, 16'h2222, 1'b0)});
    a = {mk(1'b0, 3'd1, 16'h0, 1'b0), mk(1'b0, 3'd1, 16'h0, 1'b0), mk(1'b0, 3'd1, 16'h0, 1'b0)};
    b = {mk(1'b0, 3'd2, 16'h0, 1'b0), mk(1'b0, 3'd2, 16'h0, 1'b0), mk(1'b0, 3'd2, 16'h0, 1'b0)};
    run(a, b);
    // reset in the SERVE cycle of a port 1 write
    {bus.req1, bus.we1, bus.addr1, bus.wdata1} = {1'b1, 1'b1, 3'd5, 16'h1234};
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_load", 32'(bus.ram_load), 0);
    bus.req1 = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_after", 32'(bus.busy), 0);
    chk("abort_ack1", 32'(bus.ack1), 0);
    rst_n = 1'b1;
    m_prio = 0;
    m_lock = 0;
    @(posedge clk);
    #1;
    chk("abort_ack1_late", 32'(bus.ack1), 0);
    run({mk(1'b0, 3'd5, 16'h0, 1'b0)}, {mk(1'b0, 3'd5, 16'h0, 1'b0)});
    // idle hold
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_load", 32'(bus.ram_load), 0);
    end
    // random batches
    repeat (40) begin
      a = {};
      b = {};
      repeat ($urandom_range(0, 3)) a.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 1'b0));
      repeat ($urandom_range(0, 3)) b.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 1'b0));
      run(a, b);
    end
`ifdef ARB_LOCK_EN
    // port 0 keeps the RAM while lock0 is high; port 1 waits
    a = {mk(1'b1, 3'd6, 16'hA001, 1'b1), mk(1'b1, 3'd6, 16'hA002, 1'b1), mk(1'b1, 3'd6, 16'hA003, 1'b1),
         mk(1'b1, 3'd6, 16'hA004, 1'b1), mk(1'b0, 3'd6, 16'h0, 1'b0)};
    b = {mk(1'b0, 3'd6, 16'h0, 1'b0)};
    run(a, b);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
